regfile_debug_port: RTL and testbench

// Debug-side access to the register file. Accepts read/write/dump commands from a debug host over

---
 rtl/regfile_debug_port_if.sv | 29 ++
 rtl/regfile_debug_port.sv | 250 +++++++++++++++++++++++++
 tb/tb_regfile_debug_port.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_debug_port_if.sv
// Debug host <-> regfile_debug_port channel: command in, response stream out.
// Both directions use valid/ready.
interface regfile_debug_port_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/regfile_debug_port.sv
// Debug access to the register file: halts the core, then reads through the spare read
// port or writes through the write port, and streams results back to the host.
module regfile_debug_port #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    regfile_debug_port_if.slave dbg,
    output logic                stall_req,
    input  logic                stall_ack,
    output logic [ADDR_W-1:0]   rf_dest_read,
    input  logic [DATA_W-1:0]   rf_dest_value,
    output logic                rf_wrd,
    output logic [ADDR_W-1:0]   rf_addr_d,
    output logic [DATA_W-1:0]   rf_d
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_HALT, S_EXEC, S_RESP} state_t;

    state_t            state_q, state_n;
    logic              exec_ph_q, exec_ph_n;
    logic [1:0]        op_q, op_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] data_q, data_n;
    logic [ADDR_W-1:0] idx_q, idx_n;
    logic              cmd_ready_q, cmd_ready_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_n;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_n;
    logic              rsp_last_q, rsp_last_n;
    logic              rsp_err_q, rsp_err_n;
    logic              stall_req_q, stall_req_n;
    logic [ADDR_W-1:0] rd_idx_q, rd_idx_n;
    logic              wr_pulse_q, wr_pulse_n;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_n;
    logic [DATA_W-1:0] wr_data_q, wr_data_n;

    logic accept;
    logic rsp_hs;

    assign accept = (state_q == S_IDLE) && cmd_ready_q && dbg.cmd_valid;
    assign rsp_hs = rsp_valid_q && dbg.rsp_ready;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            exec_ph_q   <= 1'b0;
            op_q        <= 2'b00;
            addr_q      <= '0;
            data_q      <= '0;
            idx_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            stall_req_q <= 1'b0;
            rd_idx_q    <= '0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_n;
            exec_ph_q   <= exec_ph_n;
            op_q        <= op_n;
            addr_q      <= addr_n;
            data_q      <= data_n;
            idx_q       <= idx_n;
            cmd_ready_q <= cmd_ready_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_addr_q  <= rsp_addr_n;
            rsp_data_q  <= rsp_data_n;
            rsp_last_q  <= rsp_last_n;
            rsp_err_q   <= rsp_err_n;
            stall_req_q <= stall_req_n;
            rd_idx_q    <= rd_idx_n;
            wr_pulse_q  <= wr_pulse_n;
            wr_addr_q   <= wr_addr_n;
            wr_data_q   <= wr_data_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE: if (accept) state_n = (dbg.cmd_op == OP_RSVD) ? S_RESP : S_HALT;
            S_HALT: if (stall_ack) state_n = S_EXEC;
            S_EXEC: if (!stall_ack || exec_ph_q) state_n = S_RESP;
            S_RESP: begin
                if (rsp_hs) begin
                    if (rsp_last_q)      state_n = S_IDLE;
                    else if (!stall_ack) state_n = S_RESP;
                    else                 state_n = S_EXEC;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        exec_ph_n   = exec_ph_q;
        op_n        = op_q;
        addr_n      = addr_q;
        data_n      = data_q;
        idx_n       = idx_q;
        rsp_valid_n = rsp_valid_q;
        rsp_addr_n  = rsp_addr_q;
        rsp_data_n  = rsp_data_q;
        rsp_last_n  = rsp_last_q;
        rsp_err_n   = rsp_err_q;
        stall_req_n = stall_req_q;
        rd_idx_n    = rd_idx_q;
        wr_pulse_n  = wr_pulse_q;
        wr_addr_n   = wr_addr_q;
        wr_data_n   = wr_data_q;
        cmd_ready_n = (state_n == S_IDLE) && !stall_ack;

        case (state_q)
            S_IDLE: begin
                exec_ph_n = 1'b0;
                if (accept) begin
                    op_n   = dbg.cmd_op;
                    addr_n = dbg.cmd_addr;
                    data_n = dbg.cmd_data;
                    if (dbg.cmd_op == OP_RSVD) begin
                        rsp_valid_n = 1'b1;
                        rsp_addr_n  = dbg.cmd_addr;
                        rsp_data_n  = '0;
                        rsp_last_n  = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        stall_req_n = 1'b1;
                    end
                end
            end
            S_HALT: exec_ph_n = 1'b0;
            S_EXEC: begin
                if (!stall_ack) begin
                    // Halt lost: abort with an error response
                    wr_pulse_n  = 1'b0;
                    exec_ph_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_addr_n  = (op_q == OP_DUMP) ? idx_q : addr_q;
                    rsp_data_n  = '0;
                    rsp_last_n  = 1'b1;
                    rsp_err_n   = 1'b1;
                end else if (!exec_ph_q) begin
                    exec_ph_n = 1'b1;
                    case (op_q)
                        OP_READ:  rd_idx_n = addr_q;
                        OP_DUMP:  rd_idx_n = idx_q;
                        OP_WRITE: begin
                            if (addr_q != '0) begin
                                wr_pulse_n = 1'b1;
                                wr_addr_n  = addr_q;
                                wr_data_n  = data_q;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    exec_ph_n   = 1'b0;
                    wr_pulse_n  = 1'b0;
                    rsp_valid_n = 1'b1;
                    case (op_q)
                        OP_READ: begin
                            rsp_addr_n = addr_q;
                            rsp_data_n = rf_dest_value;
                            rsp_last_n = 1'b1;
                            rsp_err_n  = 1'b0;
                        end
                        OP_WRITE: begin
                            rsp_addr_n = addr_q;
                            rsp_data_n = data_q;
                            rsp_last_n = 1'b1;
                            rsp_err_n  = (addr_q == '0);
                        end
                        OP_DUMP: begin
                            rsp_addr_n = idx_q;
                            rsp_data_n = rf_dest_value;
                            rsp_last_n = (idx_q == LAST_IDX);
                            rsp_err_n  = 1'b0;
                        end
                        default: begin
                            rsp_addr_n = addr_q;
                            rsp_data_n = '0;
                            rsp_last_n = 1'b1;
                            rsp_err_n  = 1'b1;
                        end
                    endcase
                end
            end
            S_RESP: begin
                if (rsp_hs) begin
                    if (rsp_last_q) begin
                        rsp_valid_n = 1'b0;
                        rsp_last_n  = 1'b0;
                        rsp_err_n   = 1'b0;
                        stall_req_n = 1'b0;
                        idx_n       = '0;
                    end else if (!stall_ack) begin
                        rsp_valid_n = 1'b1;
                        rsp_addr_n  = idx_q + ONE_IDX;
                        rsp_data_n  = '0;
                        rsp_last_n  = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else begin
                        // Next DUMP index: issue the read now, capture on the next edge
                        rsp_valid_n = 1'b0;
                        idx_n       = idx_q + ONE_IDX;
                        rd_idx_n    = idx_q + ONE_IDX;
                        exec_ph_n   = 1'b1;
                    end
                end else if (!stall_ack && !(rsp_err_q && rsp_last_q)) begin
                    rsp_last_n = 1'b1;
                    rsp_err_n  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign dbg.cmd_ready = cmd_ready_q;
    assign dbg.rsp_valid = rsp_valid_q;
    assign dbg.rsp_addr  = rsp_addr_q;
    assign dbg.rsp_data  = rsp_data_q;
    assign dbg.rsp_last  = rsp_last_q;
    assign dbg.rsp_err   = rsp_err_q;
    assign stall_req     = stall_req_q;
    assign rf_dest_read  = rd_idx_q;
    // Write enable is qualified by the live halt acknowledge so a lost halt never writes
    assign rf_wrd        = wr_pulse_q & stall_ack;
    assign rf_addr_d     = wr_addr_q;
    assign rf_d          = wr_data_q;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Directed bench for regfile_debug_port: regfile and core-halt models plus a response scoreboard.
module tb_regfile_debug_port;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              err;
        logic              chk_addr;
        logic              chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_debug_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg ();

    logic              stall_req;
    logic              stall_ack;
    logic [ADDR_W-1:0] rf_dest_read;
    logic [DATA_W-1:0] rf_dest_value;
    logic              rf_wrd;
    logic [ADDR_W-1:0] rf_addr_d;
    logic [DATA_W-1:0] rf_d;

    regfile_debug_port #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .dbg          (dbg),
        .stall_req    (stall_req),
        .stall_ack    (stall_ack),
        .rf_dest_read (rf_dest_read),
        .rf_dest_value(rf_dest_value),
        .rf_wrd       (rf_wrd),
        .rf_addr_d    (rf_addr_d),
        .rf_d         (rf_d)
    );

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Regfile model: x0 hardwired to zero, writes land on the negedge
    logic [DATA_W-1:0] mem [NUM_REGS];
    int preload_req = 2;
    assign rf_dest_value = mem[rf_dest_read];
    always @(negedge clk) begin
        if (preload_req != 0) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                mem[i] = (preload_req == 2 && i == 5) ? 32'hDEADBEEF : 32'(i * 4);
        end else if (rf_wrd && rf_addr_d != '0) begin
            mem[rf_addr_d] = rf_d;
        end
    end

    // Core model: acknowledges a halt request after ack_delay cycles
    int ack_delay = 1;
    int ack_kill  = 0;
    int ack_cnt   = 0;
    always @(posedge clk) begin
        #2;
        if (!stall_req || ack_kill != 0) begin
            ack_cnt   = 0;
            stall_ack = 1'b0;
        end else begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) stall_ack = 1'b1;
        end
    end

    // Host response-ready driver: 0 hold low, 1 always ready, 2 random
    int ready_mode = 1;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       dbg.rsp_ready = 1'b0;
            1:       dbg.rsp_ready = 1'b1;
            default: dbg.rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor: scoreboard pop, hold-stability, write-enable and latency tracking
    int   rsp_count = 0, wrd_cycles = 0, stall_cnt = 0;
    int   ack_rise_cyc = 0, rsp_rise_cyc = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [DATA_W-1:0] last_wr_data = '0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1, prev_ack = 1'b0;
    logic [ADDR_W+DATA_W+1:0] prev_pkt = '0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (stall_ack && !prev_ack) ack_rise_cyc = cyc;
            if (dbg.rsp_valid && !prev_valid) rsp_rise_cyc = cyc;
            if (stall_req) stall_cnt++;
            if (rf_wrd) begin
                wrd_cycles++;
                last_wr_addr = rf_addr_d;
                last_wr_data = rf_d;
                chk("wrd_without_ack", 64'(stall_ack), 64'd1);
            end
            if (prev_valid && !prev_ready && !prev_reset)
                chk("rsp_stable", 64'({dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, dbg.rsp_err}),
                    64'(prev_pkt));
            if (dbg.rsp_valid && dbg.rsp_ready) begin
                rsp_count++;
                chk("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk_addr) chk("rsp_addr", 64'(dbg.rsp_addr), 64'(mon_e.addr));
                    if (mon_e.chk_data) chk("rsp_data", 64'(dbg.rsp_data), 64'(mon_e.data));
                    chk("rsp_last", 64'(dbg.rsp_last), 64'(mon_e.last));
                    chk("rsp_err", 64'(dbg.rsp_err), 64'(mon_e.err));
                end
            end
        end
        prev_valid = dbg.rsp_valid;
        prev_ready = dbg.rsp_ready;
        prev_reset = reset;
        prev_ack   = stall_ack;
        prev_pkt   = {dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, dbg.rsp_err};
    end

    task automatic push(input int addr, input logic [31:0] data, input logic last, input logic err,
                        input logic ca, input logic cd);
        exp_t e;
        e.addr = ADDR_W'(addr); e.data = data; e.last = last; e.err = err;
        e.chk_addr = ca; e.chk_data = cd;
        sb.push_back(e);
    endtask

    task automatic send_cmd(input logic [1:0] op, input int addr, input logic [31:0] data);
        logic acc;
        acc = 1'b0;
        dbg.cmd_op = op; dbg.cmd_addr = ADDR_W'(addr); dbg.cmd_data = data;
        dbg.cmd_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = dbg.cmd_ready;
            @(posedge clk); #1;
        end
        dbg.cmd_valid = 1'b0;
        chk("cmd_accept", 64'(acc), 64'd1);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        for (int i = 0; i < budget && rsp_count < target; i++) @(posedge clk);
        #1;
        chk("rsp_count", 64'(rsp_count), 64'(target));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int base, s0, w0;
    logic got_v;
    initial begin
        reset = 1'b1;
        dbg.cmd_valid = 1'b0; dbg.cmd_op = 2'b00; dbg.cmd_addr = '0; dbg.cmd_data = '0;
        cycles(3);
        @(negedge clk);
        chk("reset_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
        chk("reset_stall_req", 64'(stall_req), 64'd0);
        chk("reset_rf_wrd", 64'(rf_wrd), 64'd0);
        chk("reset_cmd_ready", 64'(dbg.cmd_ready), 64'd0);
        chk("reset_rsp_err", 64'(dbg.rsp_err), 64'd0);
        @(posedge clk); #1;
        preload_req = 0;
        reset = 1'b0;

        // READ x5 with a 3-cycle halt acknowledge
        ack_delay = 3;
        push(5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1);
        send_cmd(2'b00, 5, 32'h0);
        wait_rsp(1, 100);
        chk("read_latency", 64'(rsp_rise_cyc - ack_rise_cyc), 64'd3);
        @(negedge clk);
        chk("read_stall_drop", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        ack_delay = 1;

        // WRITE x7 then READ it back
        w0 = wrd_cycles;
        push(7, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1);
        send_cmd(2'b01, 7, 32'h12345678);
        wait_rsp(2, 100);
        chk("write_wrd_cycles", 64'(wrd_cycles - w0), 64'd1);
        chk("write_addr", 64'(last_wr_addr), 64'd7);
        chk("write_data", 64'(last_wr_data), 64'h12345678);
        push(7, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b1);
        send_cmd(2'b00, 7, 32'h0);
        wait_rsp(3, 100);

        // WRITE x0 is refused; x0 still reads zero
        w0 = wrd_cycles;
        push(0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1);
        send_cmd(2'b01, 0, 32'hFFFFFFFF);
        wait_rsp(4, 100);
        chk("x0_no_wrd", 64'(wrd_cycles - w0), 64'd0);
        push(0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        send_cmd(2'b00, 0, 32'h0);
        wait_rsp(5, 100);

        // DUMP with random host backpressure
        preload_req = 1;
        @(negedge clk); #1;
        preload_req = 0;
        for (int i = 0; i < int'(NUM_REGS); i++)
            push(i, 32'(i * 4), i == int'(NUM_REGS) - 1, 1'b0, 1'b1, 1'b1);
        ready_mode = 2;
        send_cmd(2'b10, 0, 32'h0);
        wait_rsp(5 + 32, 3000);
        ready_mode = 1;
        chk("dump_sb_empty", 64'(sb.size()), 64'd0);
        cycles(2);

        // DUMP with halt lost after the 10th response
        base = rsp_count;
        for (int i = 0; i < 10; i++) push(i, 32'(i * 4), 1'b0, 1'b0, 1'b1, 1'b1);
        push(10, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_cmd(2'b10, 0, 32'h0);
        wait_rsp(base + 10, 200);
        ack_kill = 1;
        wait_rsp(base + 11, 50);
        got_v = 1'b0;
        for (int i = 0; i < 50 && !got_v; i++) begin @(negedge clk); got_v = dbg.cmd_ready; end
        chk("abort_cmd_ready", 64'(got_v), 64'd1);
        chk("abort_stall_req", 64'(stall_req), 64'd0);
        cycles(5);
        chk("abort_no_more_rsp", 64'(rsp_count), 64'(base + 11));
        ack_kill = 0;

        // Reset in the middle of a DUMP
        base = rsp_count;
        for (int i = 0; i < int'(NUM_REGS); i++)
            push(i, 32'(i * 4), i == int'(NUM_REGS) - 1, 1'b0, 1'b1, 1'b1);
        send_cmd(2'b10, 0, 32'h0);
        wait_rsp(base + 5, 200);
        pulse_reset();
        @(negedge clk);
        chk("rst_dump_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
        chk("rst_dump_stall_req", 64'(stall_req), 64'd0);
        chk("rst_dump_rf_wrd", 64'(rf_wrd), 64'd0);
        s0 = stall_cnt;
        cycles(10);
        chk("rst_dump_no_rsp", 64'(rsp_count), 64'(base + 5));
        chk("rst_dump_no_stall", 64'(stall_cnt), 64'(s0));

        // Reserved op: error response, no halt
        base = rsp_count;
        s0 = stall_cnt;
        push(3, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        send_cmd(2'b11, 3, 32'hA5A5A5A5);
        wait_rsp(base + 1, 50);
        chk("rsvd_no_stall", 64'(stall_cnt), 64'(s0));

        // Reset while a reserved-op response is held by the host
        ready_mode = 0;
        cycles(1);
        send_cmd(2'b11, 9, 32'h0);
        got_v = 1'b0;
        for (int i = 0; i < 20 && !got_v; i++) begin @(negedge clk); got_v = dbg.rsp_valid; end
        chk("rsvd_rsp_valid", 64'(got_v), 64'd1);
        chk("rsvd_rsp_err", 64'(dbg.rsp_err), 64'd1);
        chk("rsvd_stall_req", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        pulse_reset();
        @(negedge clk);
        chk("rst_rsvd_rsp_valid", 64'(dbg.rsp_valid), 64'd0);
        @(posedge clk); #1;
        ready_mode = 1;
        cycles(5);
        chk("rst_rsvd_no_rsp", 64'(rsp_count), 64'(base + 1));
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
